image_frame_builder: RTL and testbench

Upstream stage of the strip-based digit classifier: takes a raster-order stream of binary pixels, assembles one HEIGHT x LENGTH frame in a register array, and presents it with a valid/ack handshake to the vertical-strip extractor. While filling, it also computes a per-column occupancy vector, the leftmost occupied column and a blank-frame flag. These let the strip stage index the frame directly instead of scanning it combinationally.

---
 rtl/image_frame_builder.sv | 117 +++++++++++
 tb/tb_image_frame_builder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_builder.sv
// image_frame_builder: assembles a raster-order binary pixel stream into one
// HEIGHT x LENGTH frame and holds it for the strip extractor. While filling it
// tracks per-column occupancy, the leftmost inked column and a blank flag.
//
// Handshakes: a pixel beat transfers on any rising edge where pix_valid and
// pix_ready are both high; the source keeps the beat stable until then.
// The frame side uses valid/ack: image_valid stays high (frame frozen) until
// image_ack is sampled high, after which the block returns to IDLE.
module image_frame_builder #(
    parameter  int HEIGHT = 200,
    parameter  int LENGTH = 200,
    localparam int CW     = (LENGTH > 1) ? $clog2(LENGTH) : 1,
    localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic                           pix_data,
    input  logic                           pix_sof,
    output logic [HEIGHT-1:0][LENGTH-1:0]  image,
    output logic                           image_valid,
    input  logic                           image_ack,
    output logic [LENGTH-1:0]              col_nonzero,
    output logic [CW-1:0]                  first_col,
    output logic                           blank,
    output logic                           frame_err,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [CW-1:0]  tracker;
    logic           accept;
    logic           last_pix;
    logic           ink_seen;

    assign accept      = pix_valid && pix_ready;
    assign last_pix    = (row == RW'(HEIGHT - 1)) && (col == CW'(LENGTH - 1));
    assign ink_seen    = |col_nonzero;
    assign pix_ready   = (state != HOLD);
    assign image_valid = (state == HOLD);
    assign first_col   = ink_seen ? tracker : '0;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: sof (re)starts a frame, the last pixel freezes it, ack releases it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && pix_sof) state_nxt = FILL;
            FILL: if (accept && !pix_sof && last_pix) state_nxt = HOLD;
            HOLD: if (image_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame storage, raster counters and the occupancy/leftmost-column trackers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image       <= '0;
            col_nonzero <= '0;
            tracker     <= '0;
            blank       <= 1'b0;
            frame_err   <= 1'b0;
            row         <= '0;
            col         <= '0;
        end else begin
            frame_err <= 1'b0;
            if (accept && pix_sof) begin
                // A sof inside FILL abandons the partial frame; stale image bits
                // past this point get rewritten before the new frame completes.
                frame_err      <= (state == FILL);
                image[0][0]    <= pix_data;
                col_nonzero    <= '0;
                col_nonzero[0] <= pix_data;
                tracker        <= '0;
                blank          <= ~pix_data;
                if (LENGTH == 1) begin
                    row <= RW'(1);
                    col <= '0;
                end else begin
                    row <= '0;
                    col <= CW'(1);
                end
            end else if (accept && state == FILL) begin
                image[row][col]  <= pix_data;
                col_nonzero[col] <= col_nonzero[col] | pix_data;
                blank            <= ~(ink_seen | pix_data);
                if (pix_data && (!ink_seen || col < tracker))
                    tracker <= col;
                // Counters stop at the last pixel; the next sof reloads them.
                if (!last_pix) begin
                    if (col == CW'(LENGTH - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_image_frame_builder.sv
// tb_image_frame_builder: directed frames on a 4x4 instance. The driver pushes
// the expected frame summary when a frame is issued; a monitor pops and
// compares on every rising edge of image_valid.
module tb_image_frame_builder;

    localparam int H = 4;
    localparam int L = 4;
    localparam int W = 23;  // {image[15:0], col_nonzero[3:0], first_col[1:0], blank}

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic              pix_data = 1'b0;
    logic              pix_sof = 1'b0;
    logic [H-1:0][L-1:0] image;
    logic              image_valid;
    logic              image_ack = 1'b0;
    logic [L-1:0]      col_nonzero;
    logic [1:0]        first_col;
    logic              blank;
    logic              frame_err;
    logic [1:0]        dbg_state;

    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           err_cycles = 0;
    logic         valid_q = 1'b0;

    image_frame_builder #(.HEIGHT(H), .LENGTH(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .image       (image),
        .image_valid (image_valid),
        .image_ack   (image_ack),
        .col_nonzero (col_nonzero),
        .first_col   (first_col),
        .blank       (blank),
        .frame_err   (frame_err),
        .dbg_state   (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Reference summary derived from the pixel list: bit r*4+c is pixel (r,c).
    function automatic logic [W-1:0] model(input logic [15:0] f);
        logic [3:0] cnz;
        logic [1:0] fc;
        cnz = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++)
                cnz[c] = cnz[c] | f[r*L+c];
        fc = '0;
        for (int c = L - 1; c >= 0; c--)
            if (cnz[c]) fc = 2'(c);
        return {f, cnz, fc, (cnz == 4'b0000)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Monitor: count frame_err cycles and score every new frame presentation.
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (frame_err) err_cycles++;
        if (image_valid && !valid_q) begin
            vectors++;
            got = {image, col_nonzero, first_col, blank};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame: got %0h want no frame", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL frame_summary: got %0h want %0h", got, exp);
                end
            end
        end
        valid_q = image_valid;
    end

    // Driver: all tasks start and end at posedge+1.
    task automatic beat(input logic d, input logic s);
        int guard;
        guard = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        while (!pix_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!pix_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got pix_ready 0 want 1");
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f);
        exp_q.push_back(model(f));
        for (int k = 0; k < H * L; k++)
            beat(f[k], k == 0);
        check("valid_after_last", {31'd0, image_valid}, 32'd1);
    endtask

    task automatic ack();
        image_ack = 1'b1;
        @(posedge clk); #1;
        image_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_image"}, {16'd0, image}, 32'd0);
        check({tag, "_valid"}, {31'd0, image_valid}, 32'd0);
        check({tag, "_first_col"}, {30'd0, first_col}, 32'd0);
        check({tag, "_blank"}, {31'd0, blank}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_ready"}, {31'd0, pix_ready}, 32'd1);
        check({tag, "_col_nonzero"}, {28'd0, col_nonzero}, 32'd0);
    endtask

    initial begin
        // Power-on reset.
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ink pixel at (2,3); held output then ack.
        send_frame(16'h0800);
        ack();
        check("ack1_valid", {31'd0, image_valid}, 32'd0);
        check("ack1_ready", {31'd0, pix_ready}, 32'd1);

        // Blank frame, ack, then next sof immediately.
        send_frame(16'h0000);
        ack();
        check("ack2_valid", {31'd0, image_valid}, 32'd0);
        check("ack2_ready", {31'd0, pix_ready}, 32'd1);

        // Ink at (0,2) and (3,1); stay in HOLD afterwards.
        send_frame(16'h2004);

        // Beat offered during HOLD is stalled and the frame stays frozen.
        exp_q.push_back(model(16'h8001));
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_ready", {31'd0, pix_ready}, 32'd0);
            check("hold_image", {16'd0, image}, 32'h2004);
        end
        fork
            beat(1'b1, 1'b1);
            ack();
        join
        check("held_beat_taken", {30'd0, dbg_state}, 32'd1);
        for (int k = 1; k < H * L; k++)
            beat(k == 15, 1'b0);
        check("valid_after_last", {31'd0, image_valid}, 32'd1);
        ack();

        // Non-sof beats in IDLE are dropped.
        for (int i = 0; i < 3; i++)
            beat(1'b1, 1'b0);
        check("idle_drop_state", {30'd0, dbg_state}, 32'd0);
        check("idle_drop_image", {16'd0, image}, 32'h8001);
        check("idle_drop_cnz", {28'd0, col_nonzero}, 32'h9);

        // sof again at beat 7: only the restarted frame is reported.
        check("err_before", err_cycles, 32'd0);
        beat(1'b1, 1'b1);
        for (int k = 1; k < 6; k++)
            beat(1'b1, 1'b0);
        send_frame(16'h8040);
        check("err_pulse_cycles", err_cycles, 32'd1);
        ack();

        // Reset at beat 9: partial frame discarded, then a clean frame.
        beat(1'b1, 1'b1);
        for (int k = 1; k < 8; k++)
            beat(k[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", {31'd0, image_valid}, 32'd0);
        end
        send_frame(16'h0420);
        ack();

        check("queue_drained", exp_q.size(), 32'd0);
        check("err_total", err_cycles, 32'd1);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
